writeback_select_unit: RTL and testbench

WRITEBACK_SELECT_UNIT -- requirements
Module: writeback_select_unit

---
 rtl/writeback_select_unit.sv | 126 ++++++++++++
 tb/tb_writeback_select_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_select_unit.sv
// Writeback source selector: picks the register-file write value,
// waiting for load data with a timeout and holding it until accepted.
module writeback_select_unit #(
  parameter int WIDTH     = 32,
  parameter int CONST_VAL = 227,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       memtoreg,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] mdr,
  input  logic [WIDTH-1:0] exc_addr,
  input  logic [WIDTH-1:0] pc,
  input  logic             mem_valid,
  input  logic             wb_ready,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             err_sel,
  output logic             err_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  logic [1:0]       state;
  logic [1:0]       size_q;
  logic             sext_q;
  logic [2:0]       sel_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;

  function automatic logic [WIDTH-1:0] extract(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       sz,
    input logic             sx
  );
    logic [WIDTH-1:0] r;
    case (sz)
      2'b01:   r = {{(WIDTH-16){sx & d[15]}}, d[15:0]};
      2'b10:   r = {{(WIDTH-8){sx & d[7]}}, d[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // mdr is not a direct pick here; it is resolved later in WAIT_MEM
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b0;
    case (memtoreg)
      3'b000:  sel_data = alu_out;
      3'b010:  sel_data = WIDTH'(CONST_VAL);
      3'b011:  sel_data = exc_addr;
      3'b100:  sel_data = pc;
      3'b001:  sel_data = '0;
      default: sel_bad  = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      sel_q       <= 3'b000;
      cnt         <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            size_q      <= size;
            sext_q      <= sign_ext;
            sel_q       <= memtoreg;
            cnt         <= '0;
            err_sel     <= sel_bad;
            err_timeout <= 1'b0;
            if (memtoreg == 3'b001) begin
              state <= WAIT_MEM;
            end else begin
              wb_data  <= sel_data;
              wb_valid <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_valid && sel_q == 3'b001) begin
            wb_data  <= extract(mdr, size_q, sext_q);
            wb_valid <= 1'b1;
            state    <= HOLD;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            wb_data     <= '0;
            err_timeout <= 1'b1;
            wb_valid    <= 1'b1;
            state       <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_select_unit.sv
// Scoreboard bench for writeback_select_unit: driver pushes expected
// results, a negedge monitor checks handshake, flags and data.
module tb_writeback_select_unit;

  localparam int W  = 32;
  localparam int TO = 15;
  localparam int CV = 227;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    memtoreg;
  logic [1:0]    size;
  logic          sign_ext;
  logic [W-1:0]  alu_out, mdr, exc_addr, pc;
  logic          mem_valid;
  logic          wb_ready;
  logic          wb_valid;
  logic [W-1:0]  wb_data;
  logic          busy;
  logic          err_sel;
  logic          err_timeout;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] exp_q[$];
  logic exp_valid = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_err_sel = 1'b0;
  logic exp_err_to = 1'b0;

  writeback_select_unit #(.WIDTH(W), .CONST_VAL(CV), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .memtoreg(memtoreg),
    .size(size), .sign_ext(sign_ext), .alu_out(alu_out), .mdr(mdr),
    .exc_addr(exc_addr), .pc(pc), .mem_valid(mem_valid),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .busy(busy), .err_sel(err_sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Load extraction written as plain arithmetic on the value
  function automatic logic [W-1:0] load_model(input logic [W-1:0] v,
                                              input logic [1:0] sz,
                                              input logic sx);
    longint unsigned x;
    if (sz == 2'b01) begin
      x = v % 65536;
      if (sx && x >= 32768) x = x + 64'hFFFF_0000;
    end else if (sz == 2'b10) begin
      x = v % 256;
      if (sx && x >= 128) x = x + 64'hFFFF_FF00;
    end else begin
      x = v;
    end
    return x[W-1:0];
  endfunction

  task automatic noise();
    start    = 1'($urandom);
    memtoreg = 3'($urandom);
    size     = 2'($urandom);
    sign_ext = 1'($urandom);
    alu_out  = $urandom;
    exc_addr = $urandom;
    pc       = $urandom;
  endtask

  task automatic run_txn(input logic [2:0] sel, input logic [1:0] sz,
                         input logic sx, input int delay,
                         input logic [W-1:0] val, input int rdy_wait);
    logic [W-1:0] e;
    alu_out  = $urandom;
    exc_addr = $urandom;
    pc       = $urandom;
    case (sel)
      3'b000: alu_out = val;
      3'b011: exc_addr = val;
      3'b100: pc = val;
      default: ;
    endcase
    memtoreg = sel;
    size     = sz;
    sign_ext = sx;
    start    = 1'b1;
    case (sel)
      3'b000:  e = alu_out;
      3'b001:  e = (delay < TO) ? load_model(val, sz, sx) : '0;
      3'b010:  e = W'(CV);
      3'b011:  e = exc_addr;
      3'b100:  e = pc;
      default: e = '0;
    endcase
    exp_q.push_back(e);
    @(posedge clk); #1;
    start       = 1'b0;
    exp_busy    = 1'b1;
    exp_err_sel = (sel > 3'b100);
    exp_err_to  = 1'b0;
    if (sel == 3'b001) begin
      for (int i = 0; i < ((delay < TO) ? delay : TO); i++) begin
        noise();
        mem_valid = 1'b0;
        mdr = $urandom;
        @(posedge clk); #1;
      end
      if (delay < TO) begin
        noise();
        mem_valid = 1'b1;
        mdr = val;
        @(posedge clk); #1;
        mem_valid = 1'b0;
      end else begin
        exp_err_to = 1'b1;
      end
    end
    exp_valid = 1'b1;
    for (int i = 0; i < rdy_wait; i++) begin
      noise();
      wb_ready = 1'b0;
      @(posedge clk); #1;
    end
    noise();
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready  = 1'b0;
    start     = 1'b0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("wb_valid", W'(wb_valid), W'(exp_valid));
      chk("busy", W'(busy), W'(exp_busy));
      chk("err_sel", W'(err_sel), W'(exp_err_sel));
      chk("err_timeout", W'(err_timeout), W'(exp_err_to));
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb_valid", W'(wb_valid), '0);
        end else begin
          chk("wb_data", wb_data, exp_q[0]);
          if (wb_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; memtoreg = '0; size = '0;
    sign_ext = 1'b0; alu_out = '0; mdr = '0; exc_addr = '0; pc = '0;
    mem_valid = 1'b0; wb_ready = 1'b0;
    #1;
    chk("rst_wb_valid", W'(wb_valid), '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_err_sel", W'(err_sel), '0);
    chk("rst_err_to", W'(err_timeout), '0);
    #22 reset = 1'b0;
    @(posedge clk); #1;

    run_txn(3'b010, 2'b00, 1'b0, 0, 32'h0, 0);
    run_txn(3'b001, 2'b10, 1'b1, 3, 32'h0000_00F0, 0);
    run_txn(3'b001, 2'b10, 1'b0, 3, 32'h0000_00F0, 1);
    run_txn(3'b001, 2'b01, 1'b1, 2, 32'h1234_8001, 0);
    run_txn(3'b001, 2'b00, 1'b0, 20, 32'h5555_AAAA, 0);
    run_txn(3'b001, 2'b00, 1'b0, TO-1, 32'hDEAD_BEEF, 0);
    run_txn(3'b110, 2'b00, 1'b0, 0, 32'h0, 1);
    run_txn(3'b000, 2'b11, 1'b1, 0, 32'h8000_0080, 0);
    run_txn(3'b100, 2'b10, 1'b1, 0, 32'h0000_0040, 4);
    run_txn(3'b001, 2'b11, 1'b1, 0, 32'h8765_4321, 2);

    for (int n = 0; n < 150; n++) begin
      run_txn(3'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 19)), $urandom,
              int'($urandom_range(0, 3)));
    end

    // Abandon a load mid-wait with an asynchronous reset pulse
    memtoreg = 3'b001; size = 2'b00; sign_ext = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    exp_err_sel = 1'b0;
    exp_err_to = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wb_valid", W'(wb_valid), '0);
    chk("mid_rst_wb_data", wb_data, '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_err_sel", W'(err_sel), '0);
    chk("mid_rst_err_to", W'(err_timeout), '0);
    exp_busy = 1'b0;
    reset = 1'b0;
    mem_valid = 1'b1;
    mdr = 32'hCAFE_F00D;
    repeat (4) begin
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;

    run_txn(3'b011, 2'b01, 1'b1, 0, 32'h0000_8123, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
